// File: rtl/delayed_sched_pkg.sv
// Shared types and helpers for the delayed-assignment scheduler:
// the slot record, the pending-count width and a lowest-set-bit finder.
package delayed_sched_pkg;

  localparam int SCHED_DW    = 32;
  localparam int SCHED_CW    = 8;
  localparam int SCHED_DEPTH = 8;
  localparam int PEND_W      = $clog2(SCHED_DEPTH + 1);

  // Widest request vector the pick helper understands.
  localparam int PICK_MAX = 64;
  localparam int PICK_IW  = 6;

  typedef struct packed {
    logic                valid;
    logic [SCHED_DW-1:0] data;
    logic [SCHED_CW-1:0] countdown;
    logic                late;
  } slot_t;

  typedef struct packed {
    logic               found;
    logic [PICK_IW-1:0] idx;
  } pick_t;

  // Scans from the top down so the last hit written is the lowest index.
  function automatic pick_t lowest_set(input logic [PICK_MAX-1:0] vec);
    pick_t r;
    r.found = 1'b0;
    r.idx   = 6'd0;
    for (int i = PICK_MAX - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.found = 1'b1;
        r.idx   = PICK_IW'(i);
      end else begin
        r.found = r.found;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sched_prio_pick.sv
// Lowest-index priority encoder: one-hot grant, binary index and any-hit flag.
module sched_prio_pick
  import delayed_sched_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [PICK_MAX-1:0] req_ext_s;
  pick_t               pick_s;

  // Widen the request to the helper's fixed width and decode its result.
  always_comb begin
    req_ext_s        = '0;
    req_ext_s[N-1:0] = req;
    pick_s           = lowest_set(req_ext_s);
    any              = pick_s.found;
    idx              = IW'(pick_s.idx);
    onehot           = '0;
    if (pick_s.found) begin
      onehot[idx] = 1'b1;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/delayed_assign_scheduler.sv
// Transport-delay scheduler: each accepted value is presented on the output
// exactly `delay` cycles after acceptance, with valid/ready release.
module delayed_assign_scheduler
  import delayed_sched_pkg::*;
#(
  // DW and CW must match the slot_t field widths in delayed_sched_pkg.
  parameter int DW    = SCHED_DW,
  parameter int CW    = SCHED_CW,
  parameter int DEPTH = SCHED_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sched_valid,
  output logic                       sched_ready,
  input  logic [DW-1:0]              sched_data,
  input  logic [CW-1:0]              sched_delay,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_data,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       late
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH + 1);
  localparam logic [SCHED_CW-1:0] CD_ONE = SCHED_CW'(1);

  slot_t slot_q [DEPTH];
  slot_t slot_d [DEPTH];

  logic [DEPTH-1:0] free_s, elig_s, free_oh_s, elig_oh_s;
  logic [IW-1:0]    free_idx_s, elig_idx_s;
  logic             free_any_s, elig_any_s, accept_s, pop_s;
  logic [PW-1:0]    pend_s;
  logic             unused_free_idx_s;

  // Per-slot status vectors feeding the two pickers.
  always_comb begin
    free_s = '0;
    elig_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_s[i] = ~slot_q[i].valid;
      elig_s[i] = slot_q[i].valid && (slot_q[i].countdown == '0);
    end
  end

  sched_prio_pick #(.N(DEPTH)) u_free_pick (
    .req    (free_s),
    .onehot (free_oh_s),
    .idx    (free_idx_s),
    .any    (free_any_s)
  );

  sched_prio_pick #(.N(DEPTH)) u_elig_pick (
    .req    (elig_s),
    .onehot (elig_oh_s),
    .idx    (elig_idx_s),
    .any    (elig_any_s)
  );

  assign unused_free_idx_s = ^free_idx_s;
  assign accept_s          = sched_valid && free_any_s;
  assign pop_s             = elig_any_s && out_ready;

  // Slot next-state: count down, pop or mark late, and allocate. A slot freed
  // by this edge's pop is still seen as busy here, so it cannot be refilled
  // until the following edge.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_d[i] = slot_q[i];
      if (slot_q[i].valid) begin
        if (elig_s[i]) begin
          if (pop_s && elig_oh_s[i]) begin
            slot_d[i].valid = 1'b0;
            slot_d[i].late  = 1'b0;
          end else begin
            slot_d[i].late = 1'b1;
          end
        end else begin
          slot_d[i].countdown = slot_q[i].countdown - CD_ONE;
        end
      end else if (accept_s && free_oh_s[i]) begin
        slot_d[i].valid     = 1'b1;
        slot_d[i].data      = sched_data;
        slot_d[i].countdown = sched_delay;
        slot_d[i].late      = 1'b0;
      end else begin
        slot_d[i] = slot_q[i];
      end
    end
  end

  // Slot storage; reset discards every pending event at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
    end
  end

  // Output view of the registered slots.
  always_comb begin
    pend_s = '0;
    for (int i = 0; i < DEPTH; i++) pend_s = pend_s + PW'(slot_q[i].valid);
    out_valid = elig_any_s;
    if (elig_any_s) begin
      out_data = slot_q[elig_idx_s].data;
      late     = slot_q[elig_idx_s].late;
    end else begin
      out_data = '0;
      late     = 1'b0;
    end
  end

  assign sched_ready = free_any_s;
  assign pending     = pend_s;

endmodule

// File: tb/tb_delayed_assign_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against an
// absolute-time event model of the scheduler.
module tb_delayed_assign_scheduler;

  localparam int DW    = 32;
  localparam int CW    = 8;
  localparam int DEPTH = 8;
  localparam int PW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sched_valid;
  logic          sched_ready;
  logic [DW-1:0] sched_data;
  logic [CW-1:0] sched_delay;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [PW-1:0] pending;
  logic          late;

  int n_pass  = 0;
  int n_total = 0;

  // Model: each event holds its data and the absolute edge number at which it
  // becomes eligible; it is late once the current time has passed that edge.
  bit            m_valid [DEPTH];
  logic [DW-1:0] m_data  [DEPTH];
  int            m_due   [DEPTH];
  int            t;

  always #5 clk = ~clk;

  delayed_assign_scheduler #(.DW(DW), .CW(CW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sched_valid (sched_valid),
    .sched_ready (sched_ready),
    .sched_data  (sched_data),
    .sched_delay (sched_delay),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .pending     (pending),
    .late        (late)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", tag, obs, exp, t);
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
      m_due[i]   = 0;
    end
  endtask

  task automatic check_outputs();
    bit            ev = 1'b0;
    logic [DW-1:0] ed = '0;
    bit            el = 1'b0;
    int            cnt;
    for (int i = 0; i < DEPTH; i++) begin
      if (!ev && m_valid[i] && (t >= m_due[i])) begin
        ev = 1'b1;
        ed = m_data[i];
        el = (t > m_due[i]);
      end
    end
    cnt = model_count();
    check_eq("out_valid",   64'(out_valid),   64'(ev));
    check_eq("out_data",    64'(out_data),    64'(ed));
    check_eq("late",        64'(late),        64'(el));
    check_eq("pending",     64'(pending),     64'(cnt));
    check_eq("sched_ready", 64'(sched_ready), 64'(cnt < DEPTH));
  endtask

  // Apply one clock edge to the model, using pre-edge state for both decisions.
  task automatic model_edge(input logic sv, input logic [DW-1:0] d, input logic [CW-1:0] dly,
                            input logic ordy);
    int pop_i  = -1;
    int free_i = -1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (m_valid[i] && (t >= m_due[i])) pop_i = i;
      if (!m_valid[i]) free_i = i;
    end
    if (ordy && (pop_i >= 0)) m_valid[pop_i] = 1'b0;
    if (sv && (free_i >= 0)) begin
      m_valid[free_i] = 1'b1;
      m_data[free_i]  = d;
      m_due[free_i]   = t + 1 + int'(dly);
    end
    t++;
  endtask

  task automatic cycle(input logic sv, input logic [DW-1:0] d, input logic [CW-1:0] dly,
                       input logic ordy);
    check_outputs();
    sched_valid = sv;
    sched_data  = d;
    sched_delay = dly;
    out_ready   = ordy;
    @(posedge clk);
    model_edge(sv, d, dly, ordy);
    #1;
  endtask

  task automatic do_reset();
    sched_valid = 1'b0;
    out_ready   = 1'b0;
    rst_n       = 1'b0;
    #1;
    check_eq("rst_out_valid",   64'(out_valid),   64'd0);
    check_eq("rst_out_data",    64'(out_data),    64'd0);
    check_eq("rst_pending",     64'(pending),     64'd0);
    check_eq("rst_late",        64'(late),        64'd0);
    check_eq("rst_sched_ready", 64'(sched_ready), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_clear();
    t = 0;
    @(posedge clk);
    model_edge(1'b0, '0, '0, 1'b0);
    #1;
  endtask

  initial begin
    logic          held;
    logic          sv;
    logic          ordy;
    logic [DW-1:0] d;
    logic [CW-1:0] dly;

    rst_n       = 1'b0;
    sched_valid = 1'b0;
    sched_data  = '0;
    sched_delay = '0;
    out_ready   = 1'b0;
    t           = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle after reset, then a zero-delay event.
    repeat (2) cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b1, 32'd7, 8'd0, 1'b1);
    repeat (3) cycle(1'b0, '0, '0, 1'b1);

    // Later-scheduled, shorter-delay event overtakes an earlier one.
    cycle(1'b1, 32'd2, 8'd15, 1'b1);
    cycle(1'b1, 32'd1, 8'd10, 1'b1);
    repeat (18) cycle(1'b0, '0, '0, 1'b1);

    // Collision: both eligible together, lower slot wins, other goes late.
    cycle(1'b1, 32'h0000_000A, 8'd5, 1'b1);
    cycle(1'b1, 32'h0000_000B, 8'd4, 1'b1);
    repeat (8) cycle(1'b0, '0, '0, 1'b1);

    // Backpressure on an eligible event.
    cycle(1'b1, 32'h0000_0055, 8'd2, 1'b0);
    repeat (6) cycle(1'b0, '0, '0, 1'b0);
    repeat (2) cycle(1'b0, '0, '0, 1'b1);

    // Fill every slot, hold a ninth request until a slot frees up.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h100 + 32'(i), 8'd20, 1'b0);
    held = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic acc;
      acc = held && (model_count() < DEPTH);
      cycle(held, 32'h0000_0999, 8'd3, 1'b1);
      if (acc) held = 1'b0;
    end
    check_eq("full_drained", 64'(held), 64'd0);
    repeat (6) cycle(1'b0, '0, '0, 1'b1);

    // Reset with three events pending, one of them being presented.
    cycle(1'b1, 32'h11, 8'd0, 1'b0);
    cycle(1'b1, 32'h22, 8'd30, 1'b0);
    cycle(1'b1, 32'h33, 8'd30, 1'b0);
    check_outputs();
    do_reset();
    cycle(1'b0, '0, '0, 1'b1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 900; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        sv   = ($urandom_range(0, 99) < 45);
        ordy = ($urandom_range(0, 99) < 65);
        d    = DW'($urandom);
        dly  = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 40)) : CW'($urandom_range(0, 8));
        cycle(sv, d, dly, ordy);
      end
    end
    repeat (50) cycle(1'b0, '0, '0, 1'b1);
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
